// File: rtl/conv1x1_ofm_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : conv1x1_ofm_writer_if
// Brief    : OFM buffer write port (valid/ready word stream with byte address).
// Revision : 1.0
// ============================================================================
interface conv1x1_ofm_writer_if #(
  parameter int ADDR_W = 32
) ();
  logic              ofm_valid;
  logic              ofm_ready;
  logic [ADDR_W-1:0] ofm_addr;
  logic [31:0]       ofm_data;

  modport master (
    output ofm_valid,
    output ofm_addr,
    output ofm_data,
    input  ofm_ready
  );

  modport slave (
    input  ofm_valid,
    input  ofm_addr,
    input  ofm_data,
    output ofm_ready
  );
endinterface
`default_nettype wire

// File: rtl/conv1x1_ofm_writer.sv
`default_nettype none
// ============================================================================
// Module   : conv1x1_ofm_writer
// Brief    : Requantises four PE accumulators per capture into packed int8 words
//            and streams them to the OFM buffer. CONV1X1_OFM_RELU_EN selects ReLU.
// Revision : 1.0
// ============================================================================
module conv1x1_ofm_writer #(
  parameter int ACC_W      = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_start,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [7:0]           cfg_num_filter,
  input  logic [15:0]          cfg_num_pixel,
  input  logic [4:0]           cfg_shift,
  input  logic [3:0]           pe_finish,
  input  logic [4*ACC_W-1:0]   pe_acc,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  conv1x1_ofm_writer_if.master ofm
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_finish_d;
  logic [4:0]          r_shift;
  logic [23:0]         r_total;
  logic [23:0]         r_cap_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_stage_valid;
  logic [31:0]         r_stage_data;
  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic                r_overflow;

  logic [31:0]         w_word;
  logic [ACC_W:0]      w_rnd;
  logic                w_capture;
  logic                w_last;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_stage_load;

  // Rising edge of the all-lanes finish; a held-high finish yields one capture.
  assign w_capture    = (r_state == S_RUN) && !cfg_start &&
                        (pe_finish == 4'hF) && (r_finish_d != 4'hF);
  assign w_last       = (r_cap_cnt + 24'd1) == r_total;
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (c_PTR_W+1)'(FIFO_DEPTH));
  assign w_pop        = !w_empty && ofm.ofm_ready;
  assign w_push       = r_stage_valid && (!w_full || w_pop);
  assign w_stage_load = w_capture && (!r_stage_valid || w_push);
  assign w_rnd        = (r_shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (r_shift - 5'd1));

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_r;
    logic [7:0]            w_q;

    always_comb begin
      w_sum = $signed({pe_acc[k*ACC_W+ACC_W-1], pe_acc[k*ACC_W +: ACC_W]}) + $signed(w_rnd);
      w_r   = w_sum >>> r_shift;
`ifdef CONV1X1_OFM_RELU_EN
      if (w_r[ACC_W])
        w_q = 8'h00;
      else if (|w_r[ACC_W-1:7])
        w_q = 8'h7F;
      else
        w_q = w_r[7:0];
`else
      // In range when every bit above bit 7 matches the sign.
      if ((w_r[ACC_W:7] == '0) || (w_r[ACC_W:7] == '1))
        w_q = w_r[7:0];
      else if (w_r[ACC_W])
        w_q = 8'h80;
      else
        w_q = 8'h7F;
`endif
    end

    assign w_word[8*k +: 8] = w_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_RUN:   if (w_capture && w_last) w_state_nxt = S_DRAIN;
      // Leave DRAIN as the last word is popped so done follows the final transfer.
      S_DRAIN: if (!r_stage_valid && (r_count == {{c_PTR_W{1'b0}}, w_pop}))
                 w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (cfg_start)
      w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_finish_d    <= 4'h0;
      r_shift       <= 5'd0;
      r_total       <= 24'd0;
      r_cap_cnt     <= 24'd0;
      r_addr        <= '0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= 32'h0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= 32'h0;
    end else begin
      r_finish_d <= pe_finish;
      if (cfg_start) begin
        r_shift       <= cfg_shift;
        r_total       <= 24'(cfg_num_pixel) * (24'(cfg_num_filter) >> 2);
        r_cap_cnt     <= 24'd0;
        r_addr        <= cfg_base;
        r_stage_valid <= 1'b0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
        r_overflow    <= 1'b0;
      end else begin
        // Dropped captures still count so that completion is always reached.
        if (w_capture)
          r_cap_cnt <= r_cap_cnt + 24'd1;
        if (w_stage_load) begin
          r_stage_valid <= 1'b1;
          r_stage_data  <= w_word;
        end else if (w_push) begin
          r_stage_valid <= 1'b0;
        end
        if (w_capture && !w_stage_load)
          r_overflow <= 1'b1;
        if (w_push) begin
          r_mem[r_wr_ptr] <= r_stage_data;
          r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
          r_addr   <= r_addr + ADDR_W'(4);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign ofm.ofm_valid = !w_empty;
  assign ofm.ofm_addr  = r_addr;
  assign ofm.ofm_data  = r_mem[r_rd_ptr];
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_conv1x1_ofm_writer.sv
`default_nettype none
// Directed self-checking bench for conv1x1_ofm_writer (default or ReLU build).
module tb_conv1x1_ofm_writer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_start;
  logic [31:0]  cfg_base;
  logic [7:0]   cfg_num_filter;
  logic [15:0]  cfg_num_pixel;
  logic [4:0]   cfg_shift;
  logic [3:0]   pe_finish;
  logic [127:0] pe_acc;
  logic         busy;
  logic         done;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

`ifdef CONV1X1_OFM_RELU_EN
  localparam logic [31:0] E_BASIC = 32'h077F0005;
  localparam logic [31:0] E_ROUND = 32'h00000102;
`else
  localparam logic [31:0] E_BASIC = 32'h077FFD05;
  localparam logic [31:0] E_ROUND = 32'h80FF0102;
`endif

  always #5 clk = ~clk;

  conv1x1_ofm_writer_if #(.ADDR_W(32)) ofm ();

  conv1x1_ofm_writer #(
    .ACC_W     (32),
    .ADDR_W    (32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_start     (cfg_start),
    .cfg_base      (cfg_base),
    .cfg_num_filter(cfg_num_filter),
    .cfg_num_pixel (cfg_num_pixel),
    .cfg_shift     (cfg_shift),
    .pe_finish     (pe_finish),
    .pe_acc        (pe_acc),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .ofm           (ofm)
  );

  always @(posedge clk) begin
    if (ofm.ofm_valid && ofm.ofm_ready) begin
      wr_addr_q.push_back(ofm.ofm_addr);
      wr_data_q.push_back(ofm.ofm_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [7:0] nf,
                       input logic [15:0] np, input logic [4:0] sh);
    cfg_base       = base;
    cfg_num_filter = nf;
    cfg_num_pixel  = np;
    cfg_shift      = sh;
    cfg_start      = 1'b1;
    tick();
    cfg_start      = 1'b0;
  endtask

  task automatic capture(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3, input int hold);
    pe_acc    = {a3, a2, a1, a0};
    pe_finish = 4'hF;
    repeat (hold) tick();
    pe_finish = 4'h0;
    tick();
  endtask

  // Capture i carries small positive lanes 4i+1..4i+4 (identical in both clamp modes).
  task automatic capture_pat(input int i);
    capture(32'(4*i+1), 32'(4*i+2), 32'(4*i+3), 32'(4*i+4), 1);
  endtask

  function automatic logic [31:0] pat_word(input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = 8'(4*i + k + 1);
    return w;
  endfunction

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
  endtask

  initial begin
    bit seen;

    reset_n        = 1'b1;
    cfg_start      = 1'b0;
    cfg_base       = 32'h0;
    cfg_num_filter = 8'd4;
    cfg_num_pixel  = 16'd1;
    cfg_shift      = 5'd0;
    pe_finish      = 4'h0;
    pe_acc         = '0;
    ofm.ofm_ready  = 1'b1;
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_valid",    64'(ofm.ofm_valid), 64'(0));
    chk("rst_addr",     64'(ofm.ofm_addr),  64'(0));
    chk("rst_data",     64'(ofm.ofm_data),  64'(0));
    chk("rst_busy",     64'(busy),          64'(0));
    chk("rst_done",     64'(done),          64'(0));
    chk("rst_overflow", 64'(overflow),      64'(0));
    reset_n = 1'b1;
    tick();

    // Basic capture: two-cycle latency, done the cycle after the transfer.
    start(32'h100, 8'd4, 16'd1, 5'd0);
    chk("basic_busy", 64'(busy), 64'(1));
    capture(32'd5, 32'hFFFF_FFFD, 32'd200, 32'd7, 1);
    chk("basic_valid", 64'(ofm.ofm_valid), 64'(1));
    chk("basic_addr",  64'(ofm.ofm_addr),  64'h100);
    chk("basic_data",  64'(ofm.ofm_data),  64'(E_BASIC));
    chk("basic_nodone", 64'(done), 64'(0));
    tick();
    chk("basic_done",   64'(done),          64'(1));
    chk("basic_vlow",   64'(ofm.ofm_valid), 64'(0));
    tick();
    chk("basic_done_pulse", 64'(done), 64'(0));
    chk("basic_idle",       64'(busy), 64'(0));

    // Rounding and saturation with shift=4.
    start(32'h400, 8'd4, 16'd1, 5'd4);
    capture(32'd24, 32'd23, 32'hFFFF_FFE8, 32'hFFFF_EC78, 1);
    chk("round_data", 64'(ofm.ofm_data), 64'(E_ROUND));
    wait_done(10, seen);
    chk("round_done", 64'(seen), 64'(1));
    tick();

    // Held finish yields a single capture.
    wr_addr_q.delete();
    wr_data_q.delete();
    start(32'h600, 8'd4, 16'd2, 5'd0);
    capture(32'd1, 32'd2, 32'd3, 32'd4, 6);
    repeat (3) tick();
    chk("held_count", 64'(wr_data_q.size()), 64'(1));
    chk("held_busy",  64'(busy), 64'(1));
    chk("held_data",  64'(wr_data_q[0]), 64'h04030201);
    capture(32'd9, 32'd9, 32'd9, 32'd9, 1);
    wait_done(10, seen);
    chk("held_done",   64'(seen), 64'(1));
    chk("held_count2", 64'(wr_data_q.size()), 64'(2));
    chk("held_addr2",  64'(wr_addr_q[1]), 64'h604);
    tick();

    // Backpressure: four captures queued, stable head, then drained in order.
    wr_addr_q.delete();
    wr_data_q.delete();
    ofm.ofm_ready = 1'b0;
    start(32'h2000, 8'd8, 16'd2, 5'd0);
    for (int i = 0; i < 4; i++) capture_pat(i);
    repeat (3) tick();
    chk("bp_valid",    64'(ofm.ofm_valid), 64'(1));
    chk("bp_addr",     64'(ofm.ofm_addr),  64'h2000);
    chk("bp_data",     64'(ofm.ofm_data),  64'(pat_word(0)));
    chk("bp_overflow", 64'(overflow),      64'(0));
    ofm.ofm_ready = 1'b1;
    wait_done(20, seen);
    chk("bp_done",  64'(seen), 64'(1));
    chk("bp_count", 64'(wr_data_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
      chk($sformatf("bp_addr%0d", i), 64'(wr_addr_q[i]), 64'(32'h2000 + 32'(4*i)));
      chk($sformatf("bp_data%0d", i), 64'(wr_data_q[i]), 64'(pat_word(i)));
    end
    tick();

    // Overflow: seven captures into a four-deep FIFO plus stage register.
    wr_addr_q.delete();
    wr_data_q.delete();
    ofm.ofm_ready = 1'b0;
    start(32'h3000, 8'd4, 16'd7, 5'd0);
    for (int i = 0; i < 7; i++) capture_pat(i);
    repeat (2) tick();
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_busy", 64'(busy),     64'(1));
    ofm.ofm_ready = 1'b1;
    wait_done(30, seen);
    chk("ovf_done",  64'(seen), 64'(1));
    chk("ovf_count", 64'(wr_data_q.size()), 64'(5));
    if (wr_data_q.size() >= 5) begin
      chk("ovf_data4", 64'(wr_data_q[4]), 64'(pat_word(4)));
      chk("ovf_addr4", 64'(wr_addr_q[4]), 64'h3010);
    end
    chk("ovf_sticky", 64'(overflow), 64'(1));
    tick();

    // Restart mid-RUN with two words queued.
    ofm.ofm_ready = 1'b0;
    start(32'h300, 8'd4, 16'd4, 5'd0);
    chk("rs_ovf_clr", 64'(overflow), 64'(0));
    capture_pat(5);
    capture_pat(6);
    chk("rs_valid", 64'(ofm.ofm_valid), 64'(1));
    chk("rs_addr",  64'(ofm.ofm_addr),  64'h300);
    start(32'h500, 8'd4, 16'd4, 5'd0);
    chk("rs_vdrop",   64'(ofm.ofm_valid), 64'(0));
    chk("rs_newbase", 64'(ofm.ofm_addr),  64'h500);
    wr_addr_q.delete();
    wr_data_q.delete();
    ofm.ofm_ready = 1'b1;
    capture_pat(7);
    repeat (2) tick();
    chk("rs_count", 64'(wr_data_q.size()), 64'(1));
    if (wr_data_q.size() >= 1) begin
      chk("rs_waddr", 64'(wr_addr_q[0]), 64'h500);
      chk("rs_wdata", 64'(wr_data_q[0]), 64'(pat_word(7)));
    end

    // Asynchronous reset in the middle of a transfer cycle.
    ofm.ofm_ready = 1'b0;
    capture_pat(8);
    chk("ar_pre_valid", 64'(ofm.ofm_valid), 64'(1));
    ofm.ofm_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(ofm.ofm_valid), 64'(0));
    chk("ar_addr",  64'(ofm.ofm_addr),  64'(0));
    chk("ar_data",  64'(ofm.ofm_data),  64'(0));
    chk("ar_busy",  64'(busy),          64'(0));
    chk("ar_done",  64'(done),          64'(0));
    #10 reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv1x1_ofm_writer.md
# conv1x1_ofm_writer

Downstream stage of the 1x1 convolution controller. It collects the four parallel PE accumulators each time the controller raises `PE_finish` to close a pixel/filter-group. Each accumulator is requantised to int8 and packed into one 32-bit word. Words pass through a small FIFO onto the OFM buffer write port with sequential byte addressing, and the block signals completion once the whole output feature map has been written.

## Interface
- `ACC_W`, 32, width of each PE accumulator (signed).
- `ADDR_W`, 32, OFM address width.
- `FIFO_DEPTH`, 4, output word FIFO depth (power of 2, ≥2).

- `clk`  in  1  clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle pulse; latches cfg_*, clears counters, flushes the pipe, enters RUN.
- `cfg_base`  in  ADDR_W  OFM byte base address.
- `cfg_num_filter`  in  8  filters per pixel; multiple of 4, ≥4.
- `cfg_num_pixel`  in  16  output pixels, ≥1.
- `cfg_shift`  in  5  requant right-shift, 0..31.
- `pe_finish`  in  4  per-lane finish from the controller.
- `pe_acc`  in  4*ACC_W  lane k at bits [k*ACC_W +: ACC_W].
- `ofm_valid`  out  1  write request.
- `ofm_ready`  in  1  OFM buffer accepts the word.
- `ofm_addr`  out  ADDR_W  byte address of the word.
- `ofm_data`  out  32  lane k int8 at bits [8k+7:8k].
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `overflow`  out  1  sticky; a capture was dropped because the FIFO was full. Cleared by `cfg_start`.

## Operation
- The state machine has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `cfg_start`.
  - RUN → DRAIN when the capture count reaches `total = cfg_num_pixel * cfg_num_filter/4` (24-bit arithmetic).
  - DRAIN → DONE when the stage register and FIFO are both empty.
  - DONE → IDLE unconditionally. `done` is high only while in DONE.
- `cfg_start` in any state restarts: FIFO and stage register are flushed, counters are zeroed, `overflow` is cleared, and the state goes to RUN.
- **Capture event:** `pe_finish == 4'b1111` while the previous-cycle value of `pe_finish` was not `4'b1111`.
  - Only the rising edge counts. The controller holds `PE_finish` for several cycles, so a held-high input yields one capture.
  - Captures are honoured only in RUN. In IDLE, DRAIN and DONE they are ignored and not counted.
- **Requantisation, per lane** (computed at ACC_W+1 bits, signed):
  - `r = (acc + (shift ? 1<<(shift-1) : 0)) >>> shift`, i.e. round-half-up.
  - Clamp per Configuration; the result is int8.
- **Addressing:** the first word goes to `cfg_base`; each accepted word advances the address by 4, with modulo-2^ADDR_W wrap.
  - The controller's order (filter groups inner, pixels outer) matches the NHWC OFM layout, so the address is purely sequential.
- **Overflow:** a capture whose stage register cannot drain because the FIFO is full is dropped. `overflow` is set, but the capture is still counted, so that `done` still fires.
- **FIFO full with simultaneous pop:** a push is accepted when the FIFO is full but a pop happens in the same cycle.

## Timing
- Reset values of all outputs: `ofm_valid`=0, `ofm_addr`=0, `ofm_data`=0, `busy`=0, `done`=0, `overflow`=0. State resets to IDLE and the FIFO to empty.
- **Pipeline:**
  - Capture at cycle N registers the requantised word into the stage register at N+1.
  - The word is pushed into the FIFO at the end of N+1.
  - `ofm_valid`=1 at N+2 if the FIFO was empty. Minimum latency is 2 cycles.
- `ofm_data` and `ofm_addr` come straight from registers (FIFO head and address register). They are stable while `ofm_valid && !ofm_ready`.
- A word transfers on `ofm_valid && ofm_ready`; the address increments on the same edge.
- `ofm_valid` is never withdrawn without a transfer, except on `cfg_start` or reset.
- `done` is asserted in the cycle after the final transfer.
- Sustained throughput is 1 word per cycle with `ofm_ready`=1.
- Reset mid-operation: outputs return to their reset values immediately (asynchronously). Pending words are lost.

## Configuration
- **`CONV1X1_OFM_RELU_EN` defined:** ReLU. Lanes with `r<0` become 0, and `r>127` becomes 127.
- **Not defined:** signed saturation of `r` to [-128,127], two's-complement int8.

## Test plan
- **Basic capture:** base=0x100, num_filter=4, num_pixel=1, shift=0, acc={5,-3,200,7}.
  - With RELU_EN: one write at 0x100, data 0x077F0005, `done` 1 cycle later.
  - Without RELU_EN: data 0x077FFD05.
- **Held finish:** `pe_finish`=1111 held for 6 cycles → exactly one capture and one write.
- **Rounding:** shift=4, acc=24 → 2; acc=23 → 1; acc=-24 → -1, which becomes 0 with RELU_EN.
- **Backpressure:** num_filter=8, num_pixel=2, `ofm_ready`=0 throughout the 4 captures, then `ofm_ready`=1.
  - Expect 4 words at base, base+4, base+8, base+12 in capture order, `overflow`=0, then `done`.
- **Overflow:** FIFO_DEPTH=4, `ofm_ready`=0, 7 captures.
  - Expect `overflow`=1, exactly 5 words emitted once ready rises (4 in the FIFO plus 1 in the stage register), and `done` still asserted.
- **Restart and reset:** `cfg_start` mid-RUN with 2 words queued → `ofm_valid` drops next cycle and the address restarts at the new base. Async `reset_n` low mid-transfer → all outputs 0 immediately.
